// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: fetch-stage bundle linking the PC generator to redirect source, SRAM, btb and ID
interface fetch_pc_gen_if;
  logic redirect_en;
  logic [31:0] redirect_pc;
  logic inst_req;
  logic [31:0] inst_addr;
  logic inst_addr_ok;
  logic [31:0] btb_fetch_pc;
  logic btb_fetch_en;
  logic [31:0] btb_ret_pc;
  logic btb_taken;
  logic btb_ret_en;
  logic [4:0] btb_ret_index;
  logic pred_valid;
  logic pred_ready;
  logic [31:0] pred_pc;
  logic pred_hit;
  logic pred_taken;
  logic [31:0] pred_target;
  logic [4:0] pred_index;
  logic pred_kill;
  modport master (
    input redirect_en, redirect_pc, inst_addr_ok, btb_ret_pc, btb_taken, btb_ret_en, btb_ret_index, pred_ready,
    output inst_req, inst_addr, btb_fetch_pc, btb_fetch_en, pred_valid, pred_pc, pred_hit, pred_taken,
      pred_target, pred_index, pred_kill
  );
  modport slave (
    output redirect_en, redirect_pc, inst_addr_ok, btb_ret_pc, btb_taken, btb_ret_en, btb_ret_index, pred_ready,
    input inst_req, inst_addr, btb_fetch_pc, btb_fetch_en, pred_valid, pred_pc, pred_hit, pred_taken,
      pred_target, pred_index, pred_kill
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register, SRAM request issue, btb lookup redirect and prediction-record FIFO
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int PRED_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  fetch_pc_gen_if.master bus
);
  localparam int AW = $clog2(PRED_DEPTH);
  localparam int CW = AW + 1;
  typedef struct packed {
    logic [31:0] pc;
    logic hit;
    logic taken;
    logic [31:0] target;
    logic [4:0] index;
    logic kill;
  } rec_t;
  rec_t fifo [PRED_DEPTH];
  rec_t head;
  logic [31:0] pc, lookup_pc;
  logic lookup_vld, wp_kill;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic fire, push, pop, tk;
  assign bus.inst_req = !reset && !bus.redirect_en && (count + CW'(lookup_vld)) < CW'(PRED_DEPTH);
  assign fire = bus.inst_req & bus.inst_addr_ok;
  assign push = lookup_vld & !bus.redirect_en;
  assign pop = bus.pred_valid & bus.pred_ready;
  assign tk = lookup_vld & !wp_kill & bus.btb_ret_en & bus.btb_taken;
  assign head = fifo[rd_ptr];
  assign bus.inst_addr = pc;
  assign bus.btb_fetch_pc = pc;
  assign bus.btb_fetch_en = fire;
  assign bus.pred_valid = count != '0;
  assign bus.pred_pc = head.pc;
  assign bus.pred_hit = head.hit;
  assign bus.pred_taken = head.taken;
  assign bus.pred_target = head.target;
  assign bus.pred_index = head.index;
  assign bus.pred_kill = head.kill;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      lookup_pc <= '0;
      lookup_vld <= 1'b0;
      wp_kill <= 1'b0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < PRED_DEPTH; i++) fifo[i] <= '0;
    end else begin
      pc <= bus.redirect_en ? bus.redirect_pc : tk ? bus.btb_ret_pc : fire ? pc + 32'd4 : pc;
      lookup_vld <= fire;
      lookup_pc <= pc;
      wp_kill <= fire & tk;
      if (bus.redirect_en) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= {lookup_pc, bus.btb_ret_en, bus.btb_ret_en & bus.btb_taken, bus.btb_ret_pc,
                           bus.btb_ret_index, wp_kill};
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
        assert (!(push && !pop && count == CW'(PRED_DEPTH)));
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed vectors for fetch_pc_gen with hand-computed expectations
module tb_fetch_pc_gen;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  fetch_pc_gen_if bus();
  fetch_pc_gen dut (.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic btb(input logic en, input logic taken, input logic [31:0] ret_pc, input logic [4:0] idx);
    bus.btb_ret_en = en;
    bus.btb_taken = taken;
    bus.btb_ret_pc = ret_pc;
    bus.btb_ret_index = idx;
  endtask
  task automatic chk_rec(input string tag, input logic [31:0] pc, input logic hit, input logic taken,
                         input logic [31:0] target, input logic [4:0] idx, input logic kill);
    check({tag, "_vld"}, bus.pred_valid, 1);
    check({tag, "_pc"}, bus.pred_pc, pc);
    check({tag, "_hit"}, bus.pred_hit, hit);
    check({tag, "_tk"}, bus.pred_taken, taken);
    check({tag, "_tgt"}, bus.pred_target, target);
    check({tag, "_idx"}, bus.pred_index, idx);
    check({tag, "_kill"}, bus.pred_kill, kill);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    bus.inst_addr_ok = 1'b1;
    bus.pred_ready = 1'b0;
    btb(0, 0, 0, 0);
    step();
    #1;
    check("rst_req0", bus.inst_req, 0);
    step();
    #1;
    check("rst_req1", bus.inst_req, 0);
    check("rst_vld", bus.pred_valid, 0);
    reset = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    // T1 sequential fetch, btb miss
    do_reset();
    bus.pred_ready = 1'b1;
    #1;
    check("t1_a0", bus.inst_addr, 32'h1c000000);
    check("t1_fen", bus.btb_fetch_en, 1);
    check("t1_fpc", bus.btb_fetch_pc, 32'h1c000000);
    step(); #1;
    check("t1_a1", bus.inst_addr, 32'h1c000004);
    check("t1_novld", bus.pred_valid, 0);
    step(); #1;
    check("t1_a2", bus.inst_addr, 32'h1c000008);
    chk_rec("t1_r0", 32'h1c000000, 0, 0, 0, 0, 0);
    step(); #1;
    chk_rec("t1_r1", 32'h1c000004, 0, 0, 0, 0, 0);
    step(); #1;
    chk_rec("t1_r2", 32'h1c000008, 0, 0, 0, 0, 0);
    // T2 taken hit on 1c000004, wrong-path 1c000008 killed and cannot redirect
    do_reset();
    bus.pred_ready = 1'b1;
    #1;
    check("t2_a0", bus.inst_addr, 32'h1c000000);
    step(); #1;
    check("t2_a1", bus.inst_addr, 32'h1c000004);
    step();
    btb(1, 1, 32'h1c000100, 7);
    #1;
    check("t2_a2", bus.inst_addr, 32'h1c000008);
    check("t2_fen", bus.btb_fetch_en, 1);
    chk_rec("t2_r0", 32'h1c000000, 0, 0, 0, 0, 0);
    step();
    btb(1, 1, 32'h1c000300, 3);
    #1;
    check("t2_redir", bus.inst_addr, 32'h1c000100);
    chk_rec("t2_r1", 32'h1c000004, 1, 1, 32'h1c000100, 7, 0);
    step();
    btb(0, 0, 0, 0);
    #1;
    check("t2_noredir", bus.inst_addr, 32'h1c000104);
    chk_rec("t2_rk", 32'h1c000008, 1, 1, 32'h1c000300, 3, 1);
    step(); #1;
    check("t2_a5", bus.inst_addr, 32'h1c000108);
    chk_rec("t2_r3", 32'h1c000100, 0, 0, 0, 0, 0);
    // T3 hit not taken, then SRAM stall
    do_reset();
    bus.pred_ready = 1'b1;
    #1;
    check("t3_a0", bus.inst_addr, 32'h1c000000);
    step();
    btb(1, 0, 32'h1c000500, 9);
    #1;
    check("t3_a1", bus.inst_addr, 32'h1c000004);
    step();
    btb(0, 0, 0, 0);
    bus.inst_addr_ok = 1'b0;
    #1;
    check("t3_seq", bus.inst_addr, 32'h1c000008);
    check("t3_req", bus.inst_req, 1);
    check("t3_nofen", bus.btb_fetch_en, 0);
    chk_rec("t3_r0", 32'h1c000000, 1, 0, 32'h1c000500, 9, 0);
    step();
    bus.inst_addr_ok = 1'b1;
    #1;
    check("t3_hold", bus.inst_addr, 32'h1c000008);
    chk_rec("t3_r1", 32'h1c000004, 0, 0, 0, 0, 0);
    // T4 credit limit with ID stalled
    do_reset();
    #1;
    check("t4_req0", bus.inst_req, 1);
    step(); step(); step(); #1;
    check("t4_a3", bus.inst_addr, 32'h1c00000c);
    check("t4_req3", bus.inst_req, 1);
    step(); #1;
    check("t4_full", bus.inst_req, 0);
    chk_rec("t4_h0", 32'h1c000000, 0, 0, 0, 0, 0);
    step();
    bus.pred_ready = 1'b1;
    #1;
    check("t4_full2", bus.inst_req, 0);
    step();
    bus.pred_ready = 1'b0;
    #1;
    check("t4_reissue", bus.inst_req, 1);
    check("t4_a4", bus.inst_addr, 32'h1c000010);
    chk_rec("t4_h1", 32'h1c000004, 0, 0, 0, 0, 0);
    step(); #1;
    check("t4_full3", bus.inst_req, 0);
    step();
    bus.pred_ready = 1'b1;
    #1;
    chk_rec("t4_d1", 32'h1c000004, 0, 0, 0, 0, 0);
    step(); #1;
    chk_rec("t4_d2", 32'h1c000008, 0, 0, 0, 0, 0);
    step(); #1;
    chk_rec("t4_d3", 32'h1c00000c, 0, 0, 0, 0, 0);
    step(); #1;
    chk_rec("t4_d4", 32'h1c000010, 0, 0, 0, 0, 0);
    // T5 redirect flushes FIFO and in-flight taken lookup, wins over a concurrent pop
    do_reset();
    step(); step(); step(); step();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h1c000200;
    bus.pred_ready = 1'b1;
    btb(1, 1, 32'h1c000900, 5);
    #1;
    check("t5_noreq", bus.inst_req, 0);
    check("t5_vld", bus.pred_valid, 1);
    check("t5_head", bus.pred_pc, 32'h1c000000);
    step();
    bus.redirect_en = 1'b0;
    btb(0, 0, 0, 0);
    #1;
    check("t5_flush", bus.pred_valid, 0);
    check("t5_addr", bus.inst_addr, 32'h1c000200);
    check("t5_req", bus.inst_req, 1);
    step(); #1;
    check("t5_a1", bus.inst_addr, 32'h1c000204);
    check("t5_nopush", bus.pred_valid, 0);
    step(); #1;
    chk_rec("t5_r0", 32'h1c000200, 0, 0, 0, 0, 0);
    // T6 reset mid-stream, then pc wrap
    do_reset();
    step(); step(); step();
    reset = 1'b1;
    #1;
    check("t6_rreq", bus.inst_req, 0);
    step();
    reset = 1'b0;
    #1;
    check("t6_vld", bus.pred_valid, 0);
    check("t6_addr", bus.inst_addr, 32'h1c000000);
    check("t6_req", bus.inst_req, 1);
    step(); #1;
    check("t6_vld2", bus.pred_valid, 0);
    step(); #1;
    chk_rec("t6_r0", 32'h1c000000, 0, 0, 0, 0, 0);
    step();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'hfffffffc;
    #1;
    check("t6_rdreq", bus.inst_req, 0);
    step();
    bus.redirect_en = 1'b0;
    #1;
    check("t6_top", bus.inst_addr, 32'hfffffffc);
    check("t6_topreq", bus.inst_req, 1);
    step(); #1;
    check("t6_wrap", bus.inst_addr, 32'h00000000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
